mips_multicycle_ctrl: RTL

//  Multicycle sequencer for the MIPS datapath: one shared ALU and one shared instruction/data memory.

---
 rtl/mips_multicycle_ctrl_if.sv | 37 +++
 rtl/mips_multicycle_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bundle between the multicycle sequencer and the MIPS datapath.
// master = sequencer side, slave = datapath side.
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       ir_write;
    logic       read_mem;
    logic       write_mem;
    logic       write_reg;
    logic       iord;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       trap;
    logic       trap_cause;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, ir_write, read_mem, write_mem, write_reg, iord,
               alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, pc_src,
               instr_done, trap, trap_cause, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, ir_write, read_mem, write_mem, write_reg, iord,
               alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, pc_src,
               instr_done, trap, trap_cause, state
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB walk with memory-stall timeout.
// state | meaning: 0 FETCH, 1 DECODE, 2 MEM_ADDR, 3 MEM_READ, 4 MEM_WB, 5 MEM_WRITE, 6 EXEC_R,
//   7 R_WB, 8 EXEC_I, 9 I_WB, 10 BRANCH, 11 JUMP, 12 JAL, 13 TRAP (held until reset)
module mips_multicycle_ctrl #(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned WAIT_W   = 8
) (
    input  logic                   clk,
    input  logic                   nrst,
    mips_multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_R_WB      = 4'd7,
        S_EXEC_I    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_JAL       = 4'd12,
        S_TRAP      = 4'd13
    } state_t;

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int unsigned           WAIT_LAST_I = (MAX_WAIT == 0) ? 0 : MAX_WAIT - 1;
    localparam logic [WAIT_W-1:0]     WAIT_LAST   = WAIT_W'(WAIT_LAST_I);
    localparam logic                  TMO_EN      = (MAX_WAIT != 0);

    state_t              state_q, state_d;
    logic [5:0]          op_q, op_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                cause_q, cause_d;

    logic       pc_write, ir_write, read_mem, write_mem, write_reg, instr_done;
    logic       iord, alu_src_a;
    logic [1:0] alu_src_b, reg_dst, mem_to_reg, pc_src;
    logic [3:0] alu_op;
    logic       mem_state, timeout;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            wait_q  <= '0;
            cause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cause_d    = cause_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        read_mem   = 1'b0;
        write_mem  = 1'b0;
        write_reg  = 1'b0;
        instr_done = 1'b0;
        iord       = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 4'b0000;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        pc_src     = 2'b00;

        mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
        timeout   = TMO_EN && mem_state && !bus.mem_ready && (wait_q == WAIT_LAST);

        unique case (state_q)
            S_FETCH: begin
                read_mem  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = bus.mem_ready;
                pc_write  = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                op_d      = bus.opcode;
                unique case (bus.opcode)
                    OP_R:                       state_d = S_EXEC_R;
                    OP_ADDI, OP_ADDIU, OP_ANDI: state_d = S_EXEC_I;
                    OP_LW, OP_SW:               state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:             state_d = S_BRANCH;
                    OP_J:                       state_d = S_JUMP;
                    OP_JAL:                     state_d = S_JAL;
                    default: begin
                        state_d = S_TRAP;
                        cause_d = 1'b0;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                read_mem = 1'b1;
                iord     = 1'b1;
                if (bus.mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                write_reg  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                write_mem  = 1'b1;
                iord       = 1'b1;
                instr_done = bus.mem_ready;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 4'b0010;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                write_reg  = 1'b1;
                reg_dst    = 2'b01;
                mem_to_reg = 2'b01;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = (op_q == OP_ANDI) ? 4'b0011 : 4'b0000;
                state_d   = S_I_WB;
            end
            S_I_WB: begin
                write_reg  = 1'b1;
                mem_to_reg = 2'b01;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 4'b0001;
                pc_src     = 2'b01;
                pc_write   = (op_q == OP_BEQ) ? bus.zero : ~bus.zero;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = 2'b10;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                // mem_to_reg=PC links the already-incremented PC into $31
                write_reg  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                pc_write   = 1'b1;
                pc_src     = 2'b10;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: begin
                state_d = S_TRAP;
                cause_d = 1'b0;
            end
        endcase

        // mem_ready is low here, so every mem_ready-qualified strobe is already 0
        if (timeout) begin
            state_d = S_TRAP;
            cause_d = 1'b1;
        end

        if (state_d != state_q)
            wait_d = '0;
        else if (mem_state && !bus.mem_ready && (wait_q != '1))
            wait_d = wait_q + 1'b1;
        else
            wait_d = wait_q;
    end

    assign bus.pc_write   = nrst & pc_write;
    assign bus.ir_write   = nrst & ir_write;
    assign bus.read_mem   = nrst & read_mem;
    assign bus.write_mem  = nrst & write_mem;
    assign bus.write_reg  = nrst & write_reg;
    assign bus.instr_done = nrst & instr_done;
    assign bus.iord       = iord;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.alu_op     = alu_op;
    assign bus.reg_dst    = reg_dst;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.pc_src     = pc_src;
    assign bus.trap       = (state_q == S_TRAP);
    assign bus.trap_cause = cause_q;
    assign bus.state      = state_q;
endmodule
